// File: rtl/wr_pntrs_and_full_pkg.sv
// Shared FIFO helpers: default geometry and width-generic Gray/binary conversion.
// Values up to CODE_W bits are coded; callers cast to their own pointer width.
package fifo_pkg;

    localparam int DEF_AWIDTH      = 3;
    localparam int DEF_SYNC_STAGES = 2;
    localparam int CODE_W          = 32;

    function automatic logic [CODE_W-1:0] bin2gray(input logic [CODE_W-1:0] bin);
        return bin ^ (bin >> 1);
    endfunction

    // Each binary bit is the XOR of all Gray bits at or above it.
    function automatic logic [CODE_W-1:0] gray2bin(input logic [CODE_W-1:0] gray);
        logic [CODE_W-1:0] bin;
        bin = '0;
        for (int i = 0; i < CODE_W; i++) begin
            bin[i] = ^(gray >> i);
        end
        return bin;
    endfunction

endpackage

// File: rtl/wr_pntrs_and_full_if.sv
// Write-side bus of the dual-clock FIFO: producer request, read-pointer input,
// RAM write port and status flags.
interface wr_pntrs_and_full_if
    import fifo_pkg::*;
#(
    parameter int AWIDTH = DEF_AWIDTH
);
    logic              wr_req_i;
    logic [AWIDTH:0]   rd_pntr_gray_i;
    logic [AWIDTH-1:0] wr_pntr_o;
    logic              wr_en_o;
    logic [AWIDTH:0]   wr_pntr_gray_rd_o;
    logic              wr_full_o;
    logic [AWIDTH:0]   wr_usedw_o;
    logic              wr_almost_full_o;

    modport master (
        output wr_req_i, rd_pntr_gray_i,
        input  wr_pntr_o, wr_en_o, wr_pntr_gray_rd_o, wr_full_o, wr_usedw_o, wr_almost_full_o
    );

    modport slave (
        input  wr_req_i, rd_pntr_gray_i,
        output wr_pntr_o, wr_en_o, wr_pntr_gray_rd_o, wr_full_o, wr_usedw_o, wr_almost_full_o
    );

endinterface

// File: rtl/wr_pntrs_and_full_gray_sync.sv
// Multi-flop synchroniser for a Gray-coded pointer crossing clock domains,
// with synchronous clear. Shared by both FIFO sides.
module gray_sync
    import fifo_pkg::*;
#(
    parameter int WIDTH  = DEF_AWIDTH + 1,
    parameter int STAGES = DEF_SYNC_STAGES
) (
    input  logic             clk,
    input  logic             sclr,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] chain [STAGES];

    always_ff @(posedge clk) begin
        if (sclr) begin
            for (int i = 0; i < STAGES; i++) begin
                chain[i] <= '0;
            end
        end else begin
            chain[0] <= d;
            for (int i = 1; i < STAGES; i++) begin
                chain[i] <= chain[i-1];
            end
        end
    end

    assign q = chain[STAGES-1];

endmodule

// File: rtl/wr_pntrs_and_full.sv
// Write-domain pointer, full and fill-level logic of the dual-clock FIFO.
// Define WR_ALMOST_FULL_EN to build the registered almost-full flag; otherwise it is tied low.
module wr_pntrs_and_full
    import fifo_pkg::*;
#(
    parameter int AWIDTH      = DEF_AWIDTH,
    parameter int SYNC_STAGES = DEF_SYNC_STAGES,
    parameter int ALMOST_FULL = 2**AWIDTH - 2
) (
    input  logic               wr_clk_i,
    input  logic               sclr_i,
    wr_pntrs_and_full_if.slave bus
);

    if (AWIDTH < 2 || SYNC_STAGES < 2 || ALMOST_FULL < 0 || ALMOST_FULL > 2**AWIDTH) begin : g_bad_params
        $error("wr_pntrs_and_full: AWIDTH/SYNC_STAGES must be >= 2 and ALMOST_FULL within 0..depth");
    end

    logic [AWIDTH:0] wr_pntr_bin;
    logic [AWIDTH:0] next_bin;
    logic [AWIDTH:0] next_gray;
    logic [AWIDTH:0] rd_gray_s;
    logic [AWIDTH:0] rd_bin_s;
    logic [AWIDTH:0] level_next;
    logic            accept;
    logic            full_next;

    gray_sync #(
        .WIDTH  (AWIDTH + 1),
        .STAGES (SYNC_STAGES)
    ) u_rd_sync (
        .clk  (wr_clk_i),
        .sclr (sclr_i),
        .d    (bus.rd_pntr_gray_i),
        .q    (rd_gray_s)
    );

    assign accept     = bus.wr_req_i & ~bus.wr_full_o;
    assign next_bin   = wr_pntr_bin + (AWIDTH+1)'(accept);
    assign next_gray  = (AWIDTH+1)'(bin2gray(CODE_W'(next_bin)));
    assign rd_bin_s   = (AWIDTH+1)'(gray2bin(CODE_W'(rd_gray_s)));
    assign level_next = next_bin - rd_bin_s;

    // Full when the write pointer is exactly one lap ahead of the synchronised read pointer.
    assign full_next = (next_gray == {~rd_gray_s[AWIDTH:AWIDTH-1], rd_gray_s[AWIDTH-2:0]});

    assign bus.wr_pntr_o = wr_pntr_bin[AWIDTH-1:0];
    assign bus.wr_en_o   = accept & ~sclr_i;

    always_ff @(posedge wr_clk_i) begin
        if (sclr_i) begin
            wr_pntr_bin           <= '0;
            bus.wr_pntr_gray_rd_o <= '0;
            bus.wr_full_o         <= 1'b0;
            bus.wr_usedw_o        <= '0;
        end else begin
            wr_pntr_bin           <= next_bin;
            bus.wr_pntr_gray_rd_o <= next_gray;
            bus.wr_full_o         <= full_next;
            bus.wr_usedw_o        <= level_next;
        end
    end

`ifdef WR_ALMOST_FULL_EN
    localparam logic [AWIDTH:0] AF_LEVEL = (AWIDTH+1)'(ALMOST_FULL);

    always_ff @(posedge wr_clk_i) begin
        if (sclr_i) begin
            bus.wr_almost_full_o <= 1'b0;
        end else begin
            bus.wr_almost_full_o <= (level_next >= AF_LEVEL);
        end
    end
`else
    assign bus.wr_almost_full_o = 1'b0;
`endif

endmodule

// File: tb/tb_wr_pntrs_and_full.sv
// Directed vector bench for wr_pntrs_and_full (AWIDTH=3, SYNC_STAGES=2, ALMOST_FULL=6).
module tb_wr_pntrs_and_full;

    localparam int AW = 3;

`ifdef WR_ALMOST_FULL_EN
    localparam bit AF_ON = 1'b1;
`else
    localparam bit AF_ON = 1'b0;
`endif

    typedef struct {
        logic          sclr;
        logic          req;
        logic [AW:0]   rd;
        logic          en;
        logic [AW-1:0] pntr;
        logic [AW:0]   gray;
        logic          full;
        logic [AW:0]   used;
        logic          af;
    } vec_t;

    logic clk = 1'b0;
    logic sclr;
    int   n_tests = 0;
    int   n_fail  = 0;
    int   edges;
    vec_t vecs[$];

    always #5 clk = ~clk;

    wr_pntrs_and_full_if #(.AWIDTH(AW)) bus ();

    wr_pntrs_and_full #(
        .AWIDTH      (AW),
        .SYNC_STAGES (2),
        .ALMOST_FULL (6)
    ) dut (
        .wr_clk_i (clk),
        .sclr_i   (sclr),
        .bus      (bus)
    );

    task automatic add(input logic s, input logic r, input logic [3:0] rd, input logic en,
                       input logic [2:0] p, input logic [3:0] g, input logic f,
                       input logic [3:0] u, input logic af);
        vec_t v;
        v.sclr = s; v.req = r; v.rd = rd; v.en = en;
        v.pntr = p; v.gray = g; v.full = f; v.used = u; v.af = af;
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input int step, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s step %0d: got %0h, expected %0h", name, step, act, exp);
        end
    endtask

    initial begin
        sclr = 1'b1;
        bus.wr_req_i = 1'b1;
        bus.rd_pntr_gray_i = '0;

        // reset with request pending
        add(1,1,4'b0000,0, 0,4'b0000,0,0,0);
        add(1,1,4'b0000,0, 0,4'b0000,0,0,0);
        // fill from empty
        add(0,1,4'b0000,1, 1,4'b0001,0,1,0);
        add(0,1,4'b0000,1, 2,4'b0011,0,2,0);
        add(0,1,4'b0000,1, 3,4'b0010,0,3,0);
        add(0,1,4'b0000,1, 4,4'b0110,0,4,0);
        add(0,1,4'b0000,1, 5,4'b0111,0,5,0);
        add(0,1,4'b0000,1, 6,4'b0101,0,6,1);
        add(0,1,4'b0000,1, 7,4'b0100,0,7,1);
        add(0,1,4'b0000,1, 0,4'b1100,1,8,1);
        add(0,1,4'b0000,0, 0,4'b1100,1,8,1);
        // read pointer moves to 1: visible on the third edge
        add(0,0,4'b0001,0, 0,4'b1100,1,8,1);
        add(0,0,4'b0001,0, 0,4'b1100,1,8,1);
        add(0,0,4'b0001,0, 0,4'b1100,0,7,1);
        add(0,1,4'b0001,1, 1,4'b1101,1,8,1);
        // read pointer moves to 8, then write until the pointer wraps
        add(0,0,4'b1100,0, 1,4'b1101,1,8,1);
        add(0,0,4'b1100,0, 1,4'b1101,1,8,1);
        add(0,0,4'b1100,0, 1,4'b1101,0,1,0);
        add(0,1,4'b1100,1, 2,4'b1111,0,2,0);
        add(0,1,4'b1100,1, 3,4'b1110,0,3,0);
        add(0,1,4'b1100,1, 4,4'b1010,0,4,0);
        add(0,1,4'b1100,1, 5,4'b1011,0,5,0);
        add(0,1,4'b1100,1, 6,4'b1001,0,6,1);
        add(0,1,4'b1100,1, 7,4'b1000,0,7,1);
        add(0,1,4'b1100,1, 0,4'b0000,1,8,1);
        add(0,1,4'b1100,0, 0,4'b0000,1,8,1);
        // read pointer moves to 11: level drops to 5
        add(0,0,4'b1110,0, 0,4'b0000,1,8,1);
        add(0,0,4'b1110,0, 0,4'b0000,1,8,1);
        add(0,0,4'b1110,0, 0,4'b0000,0,5,0);
        // reset, five writes, reset mid-fill, resume from address 0
        add(1,1,4'b0000,0, 0,4'b0000,0,0,0);
        add(0,1,4'b0000,1, 1,4'b0001,0,1,0);
        add(0,1,4'b0000,1, 2,4'b0011,0,2,0);
        add(0,1,4'b0000,1, 3,4'b0010,0,3,0);
        add(0,1,4'b0000,1, 4,4'b0110,0,4,0);
        add(0,1,4'b0000,1, 5,4'b0111,0,5,0);
        add(1,1,4'b0000,0, 0,4'b0000,0,0,0);
        add(0,1,4'b0000,1, 1,4'b0001,0,1,0);

        for (int i = 0; i < vecs.size(); i++) begin
            sclr               = vecs[i].sclr;
            bus.wr_req_i       = vecs[i].req;
            bus.rd_pntr_gray_i = vecs[i].rd;
            #1;
            check("wr_en", i, 32'(bus.wr_en_o), 32'(vecs[i].en));
            @(posedge clk);
            #1;
            check("wr_pntr", i, 32'(bus.wr_pntr_o), 32'(vecs[i].pntr));
            check("wr_gray", i, 32'(bus.wr_pntr_gray_rd_o), 32'(vecs[i].gray));
            check("wr_full", i, 32'(bus.wr_full_o), 32'(vecs[i].full));
            check("wr_usedw", i, 32'(bus.wr_usedw_o), 32'(vecs[i].used));
            check("wr_almost_full", i, 32'(bus.wr_almost_full_o), 32'(AF_ON & vecs[i].af));
        end

        // Sustained requests against a full FIFO, then release latency.
        sclr = 1'b1;
        bus.wr_req_i = 1'b0;
        bus.rd_pntr_gray_i = '0;
        @(posedge clk);
        #1;
        sclr = 1'b0;
        bus.wr_req_i = 1'b1;
        repeat (8) @(posedge clk);
        #1;
        check("fill_full", 100, 32'(bus.wr_full_o), 32'd1);
        check("fill_usedw", 100, 32'(bus.wr_usedw_o), 32'd8);
        for (int i = 0; i < 4; i++) begin
            check("blocked_en", 101 + i, 32'(bus.wr_en_o), 32'd0);
            @(posedge clk);
            #1;
            check("blocked_gray", 101 + i, 32'(bus.wr_pntr_gray_rd_o), 32'b1100);
        end
        bus.wr_req_i = 1'b0;
        bus.rd_pntr_gray_i = 4'b0001;
        edges = 0;
        for (int i = 1; i <= 10; i++) begin
            @(posedge clk);
            #1;
            if (!bus.wr_full_o) begin
                edges = i;
                break;
            end
        end
        check("release_latency", 110, 32'(edges), 32'd3);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
